// File: rtl/fft_mag_writer_pkg.sv
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared frame geometry, sample/magnitude types and FSM states for
//            the FFT magnitude writer and its freqdetect consumer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fft_pkg;

   localparam int NBINS = 1024;
   localparam int ADDRW = 10;
   localparam int DW    = 14;
   localparam int MAGW  = 28;

   typedef logic [ADDRW-1:0] bin_addr_t;
   typedef logic [MAGW-1:0]  mag_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/fft_mag_writer_mag_sq.sv
// ============================================================================
// Module   : mag_sq
// Brief    : 3-stage squared-magnitude pipeline (re^2 + im^2) carrying a
//            valid bit and the RAM address as sideband.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mag_sq
   import fft_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_flush,
   input  logic                 i_valid,
   input  bin_addr_t            i_addr,
   input  logic signed [DW-1:0] i_re,
   input  logic signed [DW-1:0] i_im,
   output logic                 o_valid,
   output bin_addr_t            o_addr,
   output mag_t                 o_mag
);

   logic                   r_v1, r_v2, r_v3;
   bin_addr_t              r_a1, r_a2, r_a3;
   logic signed [DW-1:0]   r_re1, r_im1;
   logic [2*DW-1:0]        r_rr2, r_ii2;
   mag_t                   r_sum3;

   logic signed [2*DW-1:0] w_rr;
   logic signed [2*DW-1:0] w_ii;
   mag_t                   w_sum;

   // Squares are non-negative and at most 2^(2*DW-2), so the signed product
   // can be reinterpreted as unsigned without loss.
   assign w_rr  = r_re1 * r_re1;
   assign w_ii  = r_im1 * r_im1;
   assign w_sum = MAGW'(r_rr2) + MAGW'(r_ii2);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
      end else begin
         r_v1 <= i_valid & ~i_flush;
         r_v2 <= r_v1 & ~i_flush;
         r_v3 <= r_v2 & ~i_flush;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a1   <= '0;
         r_a2   <= '0;
         r_a3   <= '0;
         r_re1  <= '0;
         r_im1  <= '0;
         r_rr2  <= '0;
         r_ii2  <= '0;
         r_sum3 <= '0;
      end else begin
         r_a1   <= i_addr;
         r_re1  <= i_re;
         r_im1  <= i_im;
         r_a2   <= r_a1;
         r_rr2  <= w_rr;
         r_ii2  <= w_ii;
         r_a3   <= r_a2;
         r_sum3 <= w_sum;
      end
   end

   assign o_valid = r_v3;
   assign o_addr  = r_a3;
   assign o_mag   = r_sum3;

endmodule

`default_nettype wire

// File: rtl/fft_mag_writer.sv
// ============================================================================
// Module   : fft_mag_writer
// Brief    : Streams FFT bins through a squared-magnitude pipeline into FFT_RAM
//            and holds each stored frame until freqdetect releases it.
//            Optional macro FFTMAG_DC_ZERO_EN forces bin 0 to be written as 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fft_mag_writer
   import fft_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sop,
   input  logic                 in_eop,
   input  logic signed [DW-1:0] in_re,
   input  logic signed [DW-1:0] in_im,
   output logic                 wren,
   output bin_addr_t            wraddr,
   output mag_t                 data,
   output logic                 fftdone,
   input  logic                 detectdone,
   output logic                 frame_err
);

   localparam bin_addr_t c_last_bin = bin_addr_t'(NBINS - 1);

   state_t    r_state;
   state_t    w_next;
   bin_addr_t r_cnt;
   logic      r_frame_err;
   logic      r_wren;
   bin_addr_t r_wraddr;
   mag_t      r_data;

   logic      w_accept;
   logic      w_launch;
   logic      w_flush;
   logic      w_err;
   bin_addr_t w_idx;
   bin_addr_t w_launch_addr;
   logic      w_mag_valid;
   bin_addr_t w_mag_addr;
   mag_t      w_mag;
   mag_t      w_wdata;

   assign in_ready = (r_state == IDLE) || (r_state == WRITE);
   assign fftdone  = (r_state == DONE);
   assign w_accept = in_valid & in_ready;
   assign w_idx    = r_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept && in_sop) begin
               w_next = WRITE;
            end
         end
         WRITE: begin
            if (w_accept && !in_sop) begin
               if (w_idx == c_last_bin) begin
                  w_next = DRAIN;
               end else if (in_eop) begin
                  w_next = IDLE;
               end
            end
         end
         DRAIN: begin
            if (r_wren && (r_wraddr == c_last_bin)) begin
               w_next = DONE;
            end
         end
         DONE: begin
            if (detectdone) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // A mid-frame sop restarts at bin 0 and takes priority over the end checks.
   always_comb begin
      w_launch      = 1'b0;
      w_flush       = 1'b0;
      w_err         = 1'b0;
      w_launch_addr = '0;
      case (r_state)
         IDLE: begin
            w_launch = w_accept & in_sop;
         end
         WRITE: begin
            if (w_accept) begin
               if (in_sop) begin
                  w_launch = 1'b1;
                  w_err    = 1'b1;
               end else if (in_eop && (w_idx != c_last_bin)) begin
                  w_flush  = 1'b1;
                  w_err    = 1'b1;
               end else begin
                  w_launch      = 1'b1;
                  w_launch_addr = w_idx;
                  w_err         = (w_idx == c_last_bin) && !in_eop;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt       <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_err;
         if (w_launch) begin
            r_cnt <= w_launch_addr;
         end
      end
   end

   mag_sq u_mag_sq (
      .clk     (clk),
      .reset   (reset),
      .i_flush (w_flush),
      .i_valid (w_launch),
      .i_addr  (w_launch_addr),
      .i_re    (in_re),
      .i_im    (in_im),
      .o_valid (w_mag_valid),
      .o_addr  (w_mag_addr),
      .o_mag   (w_mag)
   );

`ifdef FFTMAG_DC_ZERO_EN
   assign w_wdata = (w_mag_addr == '0) ? '0 : w_mag;
`else
   assign w_wdata = w_mag;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wren   <= 1'b0;
         r_wraddr <= '0;
         r_data   <= '0;
      end else begin
         r_wren <= w_mag_valid;
         if (w_mag_valid) begin
            r_wraddr <= w_mag_addr;
            r_data   <= w_wdata;
         end
      end
   end

   assign wren      = r_wren;
   assign wraddr    = r_wraddr;
   assign data      = r_data;
   assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: doc/fft_mag_writer.md
Name: fft_mag_writer

Overview:
- Upstream neighbour of freqdetect.
- Accepts the streaming complex FFT output (one bin per beat), computes the squared magnitude of each bin, and writes it into FFT_RAM (1024 x 28-bit) on the RAM write port.
- Raises fftdone once a full frame is stored, and holds off the next frame until freqdetect reports detectdone, so the RAM is never overwritten mid-search.

Parameters:
- NBINS, 1024, bins per frame; must equal the RAM depth and be a power of 2.
- ADDRW, 10, RAM address width; equals log2(NBINS).
- DW, 14, signed width of the FFT real and imaginary samples.
- MAGW, 28, RAM data width; must be at least 2*DW.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  FFT sample valid
- in_ready  out  1  block accepts a sample this cycle
- in_sop  in  1  first bin of frame; qualified by in_valid
- in_eop  in  1  last bin of frame; qualified by in_valid
- in_re  in  DW  signed real part
- in_im  in  DW  signed imaginary part
- wren  out  1  RAM write enable
- wraddr  out  ADDRW  RAM write address
- data  out  MAGW  RAM write data (squared magnitude)
- fftdone  out  1  frame fully stored; level signal
- detectdone  in  1  pulse from freqdetect; releases the frame
- frame_err  out  1  one-cycle pulse on a malformed frame

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, wren=0, wraddr=0, data=0, fftdone=0, frame_err=0. The bin counter and all pipeline valid bits are cleared.
- Handshake: a beat is accepted when in_valid && in_ready. in_ready is 1 in IDLE and WRITE, and 0 in DRAIN and DONE.
- Datapath (sub-module mag_sq):
  - Stage 1 registers re/im.
  - Stage 2 registers re*re and im*im as 2*DW-bit unsigned values.
  - Stage 3 registers the sum, zero-extended to MAGW bits.
  - Worst case (-8192)^2 * 2 = 2^27, which fits in 28 bits, so there is no saturation.
- Latency: wren rises exactly 3 cycles after the accepting edge. wraddr carries the bin index captured with the sample. Addresses are written strictly in order 0..NBINS-1.
- State machine:
  - IDLE: accepted beats without sop are dropped silently. An accepted beat with sop sets the count to 0, launches the sample, and moves to WRITE.
  - WRITE:
    - Each accepted beat increments the count.
    - An accepted beat with count==NBINS-1 ends the frame and moves to DRAIN. If that beat has eop=0, frame_err pulses but the frame is still accepted.
    - An accepted beat with eop and count<NBINS-1 pulses frame_err, flushes the pipeline, and returns to IDLE without setting fftdone.
    - An accepted beat with sop mid-frame pulses frame_err and restarts at count 0 with that beat as bin 0.
  - DRAIN: waits until the last write has issued (wren for address NBINS-1). fftdone=1 the cycle after that write; moves to DONE.
  - DONE: fftdone held at 1, in_ready=0. detectdone=1 clears fftdone on the next edge and moves to IDLE.
- Simultaneous events: detectdone in any state other than DONE is ignored. Reset mid-frame aborts the frame; partially written RAM contents are left as is and fftdone stays 0.
- The counter never wraps inside a frame; it is reloaded only by sop.

Optional Feature:
- Macro: FFTMAG_DC_ZERO_EN
- Defined: bin 0 is written with data=0 regardless of input, so the DC term never wins freqdetect's max search. Latency and address sequence are unchanged.
- Undefined: bin 0 is written with its true squared magnitude.

Decomposition:
- Package fft_pkg holds: NBINS, ADDRW, DW, MAGW; the state enum (IDLE, WRITE, DRAIN, DONE); typedefs bin_addr_t and mag_t.
- freqdetect imports the same package.
- One sub-module, mag_sq: a 3-stage squared-magnitude pipeline carrying valid and addr sideband signals.

Test Plan:
- Full frame: 1024 beats with re=0x0010, im=0 except bin 0xCC with re=0x0100, im=0x0100. Required: RAM holds 0x100 everywhere and 0x20000 at 0xCC; fftdone rises 4 cycles after the last beat is accepted; freqdetect's maxbin=0xCC.
- Extremes: re=im=-8192 (0x2000). Required: data=0x8000000, with no overflow and no sign extension.
- Back-pressure: a second sop is presented while fftdone=1. Required: in_ready=0, no wren. Pulse detectdone. Required: fftdone falls the next cycle, in_ready returns to 1, and the second frame is written.
- Short frame: eop at bin 500. Required: one-cycle frame_err pulse, fftdone stays 0, state returns to IDLE, the next sop frame completes normally.
- Mid-frame sop at bin 300. Required: frame_err pulse, and that beat is written at address 0.
- With FFTMAG_DC_ZERO_EN defined and bin 0 at re=0x1000: address 0 is written with 0.
- Reset asserted mid-frame: all outputs return to their reset values on the next edge.
